// File: rtl/regression_pkg.sv
// Shared definitions for the least-squares regression sequencer and its sibling datapath blocks.
// Holds the controller state encoding, default job geometry and the sample width.
package regression_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_INVERT = 3'd4,
        ST_COEF   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    localparam int DEF_N       = 256;
    localparam int DEF_CNT_W   = 9;
    localparam int DEF_ACC_LAT = 3;
    localparam int DEF_TIMEOUT = 255;
    localparam int WDOG_W      = 8;
    localparam int SAMPLE_W    = 12;

    function automatic logic is_busy(input state_t s);
        return !((s == ST_IDLE) || (s == ST_ERR));
    endfunction

endpackage

// File: rtl/regression_wdog.sv
// Timeout counter shared by the INVERT and COEF wait states.
// expired is high on the LIMIT-th cycle after the last clear.
module regression_wdog
    import regression_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [WDOG_W-1:0] count,
    output logic              expired
);

    logic [WDOG_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // The first cycle in a wait state sees 0, so LIMIT-1 marks the LIMIT-th cycle.
    assign expired = (count_reg == WDOG_W'(LIMIT - 1));
    assign count   = count_reg;

endmodule

// File: rtl/regression_ctrl.sv
// Sequencer for the regression datapath: clears/enables the accumulators for N samples,
// then launches inversion and coefficient compute with a shared timeout. Drives strobes only.
module regression_ctrl
    import regression_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int ACC_LAT = DEF_ACC_LAT,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             acc_last,
    output logic             inv_start,
    input  logic             inv_done,
    output logic             coef_start,
    input  logic             coef_done,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam int DRAIN_W = $clog2(ACC_LAT) + 1;

    state_t             state_reg;
    logic [CNT_W-1:0]   sample_cnt_reg;
    logic [DRAIN_W-1:0] drain_cnt_reg;

    logic               accept;
    logic               last_sample;
    logic               in_wait;
    logic               wait_done;
    logic               wdog_clr;
    logic               wdog_expired;
    logic [WDOG_W-1:0]  wdog_count;

    assign accept      = in_valid && in_ready;
    assign last_sample = (sample_cnt_reg == CNT_W'(N - 1));
    assign in_wait     = (state_reg == ST_INVERT) || (state_reg == ST_COEF);
    assign wait_done   = ((state_reg == ST_INVERT) && inv_done) ||
                         ((state_reg == ST_COEF)   && coef_done);

    // Restarting on success means COEF also begins with a zero count.
    assign wdog_clr = !in_wait || wait_done || abort;

    regression_wdog #(
        .LIMIT(TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wdog_clr),
        .en      (in_wait),
        .count   (wdog_count),
        .expired (wdog_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            sample_cnt_reg <= '0;
            drain_cnt_reg  <= '0;
        end else if (abort) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    sample_cnt_reg <= '0;
                    drain_cnt_reg  <= '0;
                    state_reg      <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (accept) begin
                        sample_cnt_reg <= sample_cnt_reg + 1'b1;
                        if (last_sample) begin
                            drain_cnt_reg <= '0;
                            state_reg     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_reg == DRAIN_W'(ACC_LAT - 1)) begin
                        state_reg <= ST_INVERT;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 1'b1;
                    end
                end
                ST_INVERT: begin
                    // A done arriving on the expiry cycle still wins.
                    if (inv_done) begin
                        state_reg <= ST_COEF;
                    end else if (wdog_expired) begin
                        state_reg <= ST_ERR;
                    end
                end
                ST_COEF: begin
                    if (coef_done) begin
                        state_reg <= ST_DONE;
                    end else if (wdog_expired) begin
                        state_reg <= ST_ERR;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                ST_ERR: begin
                    if (start) begin
                        state_reg <= ST_CLEAR;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state_reg == ST_ACCUM);
    assign acc_en     = accept;
    assign acc_last   = accept && last_sample;
    assign acc_clr    = (state_reg == ST_CLEAR);
    // Launch strobes fire only on the zero-count first cycle of their wait state.
    assign inv_start  = (state_reg == ST_INVERT) && (wdog_count == '0);
    assign coef_start = (state_reg == ST_COEF) && (wdog_count == '0);
    assign busy       = is_busy(state_reg);
    assign done       = (state_reg == ST_DONE);
    assign err        = (state_reg == ST_ERR);
    assign sample_cnt = sample_cnt_reg;

endmodule

// File: tb/tb_regression_ctrl.sv
// Scoreboard bench for regression_ctrl: expected strobe events are queued when a job is issued,
// and a negedge monitor pops and compares each event the DUT produces.
module tb_regression_ctrl;

    localparam int N       = 256;
    localparam int CNT_W   = 9;
    localparam int ACC_LAT = 3;
    localparam int TIMEOUT = 255;

    localparam int EV_CLR   = 0;
    localparam int EV_LAST  = 1;
    localparam int EV_INV   = 2;
    localparam int EV_COEF  = 3;
    localparam int EV_DONE  = 4;
    localparam int EV_ERR   = 5;
    localparam int EV_BFALL = 6;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t exp_q[$];

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic             inv_done = 1'b0;
    logic             coef_done = 1'b0;
    logic             in_ready, acc_clr, acc_en, acc_last, inv_start, coef_start;
    logic             busy, done, err;
    logic [CNT_W-1:0] sample_cnt;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int iv_mode = 0;
    int job_c = 0;
    int inv_delay = -1;
    int coef_delay = -1;
    int inv_t = -100000;
    int coef_t = -100000;
    int acc_n = 0;
    int c;

    regression_ctrl #(
        .N(N), .CNT_W(CNT_W), .ACC_LAT(ACC_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready),
        .acc_clr(acc_clr), .acc_en(acc_en), .acc_last(acc_last),
        .inv_start(inv_start), .inv_done(inv_done),
        .coef_start(coef_start), .coef_done(coef_done),
        .busy(busy), .done(done), .err(err), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EV_CLR:   return "acc_clr";
            EV_LAST:  return "acc_last";
            EV_INV:   return "inv_start";
            EV_COEF:  return "coef_start";
            EV_DONE:  return "done";
            EV_ERR:   return "err_rise";
            EV_BFALL: return "busy_fall";
            default:  return "unknown";
        endcase
    endfunction

    task automatic push(input int k, input int cy, input int v);
        ev_t e;
        e.kind = k;
        e.cyc  = cy;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Expected events for one job started at cycle cs; inv_d < 0 means inversion never answers.
    task automatic push_job(input int cs, input int last, input int inv_d, input int coef_d,
                            input bit finish);
        int it;
        int ct;
        int dt;
        push(EV_CLR, cs + 1, 1);
        push(EV_LAST, last, N - 1);
        it = last + 1 + ACC_LAT;
        push(EV_INV, it, N);
        if (inv_d < 0) begin
            push(EV_ERR, it + TIMEOUT, 0);
            push(EV_BFALL, it + TIMEOUT, 0);
        end else begin
            ct = it + inv_d + 1;
            push(EV_COEF, ct, N);
            if (finish) begin
                dt = ct + coef_d + 1;
                push(EV_DONE, dt, N);
                push(EV_BFALL, dt + 1, 1);
            end
        end
    endtask

    task automatic sb(input int kind, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected %s: got event @%0d val=%0d, required no event",
                     ev_name(kind), cyc, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val) begin
                fails++;
                $display("FAIL %s: got %s@%0d val=%0d, required %s@%0d val=%0d",
                         ev_name(e.kind), ev_name(kind), cyc, val, ev_name(e.kind), e.cyc, e.val);
            end else begin
                $display("ok   %s @%0d val=%0d", ev_name(kind), cyc, val);
            end
        end
    endtask

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, expv);
        end else begin
            $display("ok   %s = 0x%0h", name, got);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_outs"}, int'({in_ready, acc_clr, acc_en, acc_last, inv_start,
                                     coef_start, busy, done, err}), 0);
        check({name, "_cnt"}, int'(sample_cnt), 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_empty(input int limit, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d events pending after %0d cycles, required 0",
                     name, exp_q.size(), limit);
            exp_q.delete();
        end else begin
            $display("ok   %s complete @%0d", name, cyc);
        end
        repeat (3) step();
    endtask

    // Stimulus-side drivers: upstream valid pattern and inversion/coef responders.
    initial begin
        forever begin
            step();
            in_valid  = (iv_mode == 0) ? 1'b1 : (((cyc - job_c) % 2) == 0);
            inv_done  = (inv_delay >= 0) && (cyc == inv_t + inv_delay);
            coef_done = (coef_delay >= 0) && (cyc == coef_t + coef_delay);
        end
    end

    // Monitor: every visible strobe is matched against the scoreboard queue.
    initial begin
        logic busy_prev;
        logic done_prev;
        logic err_prev;
        busy_prev = 1'b0;
        done_prev = 1'b0;
        err_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (acc_clr) begin
                acc_n  = 0;
                inv_t  = -100000;
                coef_t = -100000;
                sb(EV_CLR, int'({err, busy}));
            end
            if (acc_en) acc_n++;
            if (acc_last) sb(EV_LAST, int'(sample_cnt));
            if (inv_start) begin
                inv_t = cyc;
                sb(EV_INV, int'(sample_cnt));
            end
            if (coef_start) begin
                coef_t = cyc;
                sb(EV_COEF, int'(sample_cnt));
            end
            if (done) sb(EV_DONE, acc_n);
            if (err && !err_prev) sb(EV_ERR, int'(busy));
            if (!busy && busy_prev) sb(EV_BFALL, int'(done_prev));
            busy_prev = busy;
            done_prev = done;
            err_prev  = err;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        step();

        // Reset in the middle of accumulation, then a clean job.
        iv_mode = 0; inv_delay = 5; coef_delay = 3;
        c = cyc;
        push(EV_CLR, c + 1, 1);
        pulse_start();
        goto(c + 12);
        check("cnt_before_reset", int'(sample_cnt), 10);
        push(EV_BFALL, cyc, 0);
        rst_n = 1'b0;
        step();
        check_idle("reset_mid");
        rst_n = 1'b1;
        wait_empty(10, "reset_mid_accum");

        c = cyc;
        push_job(c, c + N + 1, 5, 3, 1'b1);
        pulse_start();
        wait_empty(400, "job_continuous");

        // Valid toggling every cycle: samples accepted on alternate cycles.
        iv_mode = 1;
        c = cyc;
        job_c = c;
        push_job(c, c + 2 * N, 5, 3, 1'b1);
        pulse_start();
        wait_empty(700, "job_toggle");
        iv_mode = 0;

        // Inversion never answers: timeout into ERR.
        inv_delay = -1;
        c = cyc;
        push_job(c, c + N + 1, -1, 0, 1'b0);
        pulse_start();
        wait_empty(700, "job_timeout");

        // Restart from ERR; inversion answers on the expiry cycle; stray start ignored.
        inv_delay = TIMEOUT - 1;
        c = cyc;
        push_job(c, c + N + 1, TIMEOUT - 1, 3, 1'b1);
        pulse_start();
        goto(c + N + 5 + 10);
        pulse_start();
        wait_empty(900, "job_expiry_edge");

        // Abort in COEF coincident with coef_done: no done, no err.
        inv_delay = 5;
        c = cyc;
        push_job(c, c + N + 1, 5, 3, 1'b0);
        pulse_start();
        goto(c + N + 11 + 3);
        abort = 1'b1;
        push(EV_BFALL, cyc + 1, 0);
        step();
        abort = 1'b0;
        wait_empty(400, "abort_coef");

        // Abort and start together in IDLE: nothing starts.
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        repeat (4) step();
        check("abort_start_busy", int'(busy), 0);
        check("abort_start_err", int'(err), 0);
        wait_empty(5, "abort_start_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/regression_ctrl.md
Name: regression_ctrl

Overview:
Sequencing controller for the least-squares regression datapath in the option-pricing engine. It accepts one job of N (x, y) profit samples and clears and enables the X^T X / X^T Y accumulators. It then launches the 2x2 matrix inversion and the coefficient multiply, and signals completion. The block never touches data: it drives strobes only and counts handshakes.

Parameters:
N, 256, samples per regression job (must be >= 2)
CNT_W, 9, sample counter width (must be >= clog2(N)+1)
ACC_LAT, 3, accumulator pipeline depth (cycles from last acc_en to final sums stable)
TIMEOUT, 255, max cycles to wait for inv_done or coef_done before error (8-bit counter)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle job request; honoured only in IDLE or ERR
abort  in  1  synchronous abort; any state -> IDLE next cycle
in_valid  in  1  upstream sample valid
in_ready  out  1  sample accepted when in_valid && in_ready
acc_clr  out  1  clear XTX/XTY accumulators (one-cycle pulse)
acc_en  out  1  accumulate current sample; equals in_valid && in_ready
acc_last  out  1  marks the N-th accepted sample (coincident with acc_en)
inv_start  out  1  one-cycle pulse to launch matrix inversion
inv_done  in  1  inversion result valid (pulse or level)
coef_start  out  1  one-cycle pulse to launch coefficient/expected-profit compute
coef_done  in  1  coefficient result valid
busy  out  1  high in every state except IDLE and ERR
done  out  1  one-cycle job-complete pulse
err  out  1  timeout flag; held until next start or abort
sample_cnt  out  CNT_W  samples accepted in current job

Behaviour:
- Reset: state=IDLE; all outputs 0; sample_cnt=0; timeout counter=0.
- States: IDLE, CLEAR, ACCUM, DRAIN, INVERT, COEF, DONE, ERR. All outputs are registered or decoded from state; no combinational path from inputs to outputs except acc_en/acc_last = f(in_valid, state, count).
- IDLE: start -> CLEAR. busy=0.
- CLEAR: exactly 1 cycle, acc_clr=1, sample_cnt<=0 -> ACCUM. in_ready=0.
- ACCUM: in_ready=1. Each accepted sample increments sample_cnt. acc_last=1 when accepting with sample_cnt==N-1; that same cycle -> DRAIN and sample_cnt becomes N. No sample is ever accepted beyond N. in_valid gaps simply stall the block; there is no timeout in ACCUM.
- DRAIN: in_ready=0. Waits exactly ACC_LAT cycles (counter), then -> INVERT.
- INVERT: inv_start=1 on the first cycle only. Timeout counter cleared on entry and incremented each cycle. inv_done -> COEF. If the counter reaches TIMEOUT without inv_done -> ERR. inv_done on the expiry cycle counts as success. An inv_done asserted on the same cycle as inv_start is accepted.
- COEF: coef_start=1 on the first cycle only. Same timeout rules as INVERT with coef_done. coef_done -> DONE.
- DONE: done=1 for 1 cycle; sample_cnt holds N -> IDLE.
- ERR: err=1, busy=0. start -> CLEAR, and err clears on the same edge.
- start while busy: ignored, no side effects.
- abort: highest priority. State -> IDLE next edge; err cleared; any pending strobe is suppressed. abort and start on the same cycle -> IDLE with no job started.
- Job-to-job latency with continuous in_valid: 1 (CLEAR) + N + ACC_LAT + inversion + coef + 1 (DONE) cycles from start to done. A back-to-back start is accepted on the cycle after done (state is IDLE).
- inv_done/coef_done seen outside their own state are ignored.

Decomposition:
- Shared package regression_pkg holds: state enum encoding (3 bits), default N, ACC_LAT, TIMEOUT, and sample-width constant 12 (for sibling datapath blocks).
- One natural sub-module: regression_wdog, an 8-bit timeout counter (clear, enable, expired) shared by INVERT and COEF.
- The sample counter and drain counter stay inline.

Test Plan:
- Reset mid-ACCUM (after 10 samples) -> all outputs 0, sample_cnt=0, state IDLE; a new start then runs a clean job.
- N=256 with in_valid held high; inv_done 5 cycles after inv_start; coef_done 3 cycles after coef_start -> acc_clr at cycle 1, acc_last on the 256th acc_en, exactly 256 acc_en, DRAIN 3 cycles, done exactly once, busy low the cycle after done.
- in_valid toggling 1/0 each cycle -> job still accepts exactly 256 samples; in_valid held after acc_last gets in_ready=0.
- inv_done never asserted -> err rises 255 cycles after inv_start, busy=0; start then clears err and acc_clr pulses next cycle.
- inv_done on exactly cycle 255 -> proceeds to COEF, no err. start pulsed during INVERT -> ignored, no second acc_clr.
- abort during COEF together with a coincident coef_done -> IDLE, no done pulse, no err. abort+start in the same IDLE cycle -> remains IDLE.
